mm_reg_bank: RTL and testbench
==============================

Name: mm_reg_bank

Overview:
- Single-clock Avalon-MM slave that fans accesses out to ADDR_COUNT user registers through one-hot read and write strobes.
- Successor to the fixed 32-bit register bridge, with these additions:
  - parametrised data width and register count;
  - byte-enable partial writes forwarded to user logic;
  - burst reads with address auto-increment;
  - per-register read-valid handshake with a bounded timeout.
- Sits between the HPS/Avalon interconnect and the analyzer's control/status logic.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_SIZE, 4, width of mm_address.
- ADDR_COUNT, 2**ADDR_SIZE, number of implemented registers; must be ≤ 2**ADDR_SIZE.
- MAX_BURST, 8, largest accepted read burst length.
- BURST_W, $clog2(MAX_BURST)+1, width of mm_burstcount.
- TIMEOUT, 1023, cycles to wait for reg_readvalid before substituting TIMEOUT_DATA.
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on timeout; truncated or zero-extended to DATA_WIDTH.

Ports:
- mm_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- mm_address  in  ADDR_SIZE  word address.
- mm_burstcount  in  BURST_W  read burst length; 0 treated as 1.
- mm_waitrequest  out  1  low only in the cycle a command is accepted.
- mm_read  in  1  read request.
- mm_readdata  out  DATA_WIDTH  read data.
- mm_readdatavalid  out  1  one pulse per returned word.
- mm_write  in  1  write request.
- mm_writedata  in  DATA_WIDTH  write data.
- mm_byteenable  in  DATA_WIDTH/8  write byte lanes.
- reg_write  out  ADDR_COUNT  one-hot write strobe.
- reg_read  out  ADDR_COUNT  one-hot read strobe.
- reg_writedata  out  DATA_WIDTH  registered write data, shared by all registers.
- reg_byteenable  out  DATA_WIDTH/8  registered byte lanes, shared by all registers.
- reg_readdata  in  ADDR_COUNT*DATA_WIDTH  packed per-register read data; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_readvalid  in  ADDR_COUNT  per-register read-data-valid.
- timeout_count  out  16  saturating timeout counter (optional feature).

Behaviour:
- Reset (synchronous):
  - state IDLE; mm_waitrequest 1; mm_readdatavalid 0; mm_readdata 0.
  - reg_write, reg_read, reg_writedata, reg_byteenable all 0; internal counters 0.
  - Reset mid-burst abandons the burst: no further readdatavalid and no strobes.
- States: IDLE, WR, RD_ACC, RD_REQ, RD_WAIT.
- IDLE:
  - mm_write has priority over mm_read when both are asserted.
  - On mm_write: go to WR; latch address, data and byteenable.
  - Else on mm_read: go to RD_ACC; latch address; latch burst count = max(mm_burstcount, 1), clamped to MAX_BURST.
- WR (1 cycle):
  - mm_waitrequest 0.
  - reg_write[addr] = 1 if addr < ADDR_COUNT and byteenable ≠ 0; write dropped otherwise.
  - reg_writedata / reg_byteenable hold the latched values.
  - Next state IDLE. Minimum write spacing: 2 cycles.
- RD_ACC (1 cycle): mm_waitrequest 0; next state RD_REQ.
- RD_REQ (1 cycle):
  - reg_read[addr] = 1 if addr < ADDR_COUNT; timeout counter cleared.
  - Next state RD_WAIT.
  - reg_readvalid[addr] already high in this cycle counts; capture happens at the end of RD_REQ.
- RD_WAIT:
  - Capture when reg_readvalid[addr] is high.
  - If addr ≥ ADDR_COUNT, capture 0 in the first cycle with no timeout.
  - If TIMEOUT cycles elapse since RD_REQ without valid, capture TIMEOUT_DATA.
- Capture cycle:
  - Next cycle: mm_readdatavalid = 1 with mm_readdata = captured word.
  - Decrement remaining count; addr = addr+1, wrapping ADDR_COUNT-1 → 0.
  - Remaining > 0: go to RD_REQ; else go to IDLE.
- Read latency: acceptance at T, reg_read at T+1, earliest mm_readdatavalid at T+2.
- Beats: a burst of N gives exactly N readdatavalid pulses, in address order.
- Command acceptance: mm_waitrequest is 1 in all states except WR and RD_ACC. No new command is accepted while a burst is outstanding.
- reg_readvalid on non-selected registers is ignored.

Optional Feature:
- Macro: MM_REG_BANK_TIMEOUT_CNT_EN.
- Defined:
  - timeout_count increments by 1 on every read timeout, saturating at 16'hFFFF.
  - Cleared by reset only.
- Undefined: timeout_count is tied to 0 and no counter logic is generated.
- Read data behaviour is identical either way.

Test Plan:
- Write addr 3, data 0x12345678, byteenable 4'b0101 → one cycle reg_write = 1<<3, reg_writedata 0x12345678, reg_byteenable 0101; mm_waitrequest low exactly that cycle.
- Write with byteenable 0, then write to addr ≥ ADDR_COUNT (ADDR_COUNT=12, addr 13) → commands accepted; reg_write stays 0.
- Single read addr 2, reg_readvalid[2] tied high, reg_readdata[2]=0xA5A5A5A5 → mm_readdatavalid exactly 2 cycles after acceptance, data 0xA5A5A5A5.
- Burst read addr 14, burstcount 4, ADDR_COUNT 16 → reg_read pulses on 14, 15, 0, 1; four valid beats in that order.
- Read addr 5 with reg_readvalid[5] held low → after 1023 cycles, one beat with 0xDEADBEEF; with macro defined, timeout_count = 1.
- Assert rst during beat 2 of a 4-beat burst → next cycle: IDLE, mm_waitrequest 1, no further beats or strobes; a subsequent read completes normally.

Source files
------------

// File: rtl/mm_reg_bank.sv
// Avalon-MM slave fanning word accesses out to ADDR_COUNT user registers via one-hot strobes.
// Latency: write strobe in the accept cycle; read strobe at accept+1, first beat no earlier than accept+2.
// Backpressure: mm_waitrequest is low only in the single accept cycle (WR / RD_ACC); no new command until a burst ends.
//
// Ports:
//    mm_clk, rst          sole clock, synchronous active-high reset
//    mm_*                 Avalon-MM slave: address, burstcount, read/write, data, byteenable, waitrequest, readdatavalid
//    reg_write/reg_read   one-hot strobes to the user registers
//    reg_writedata/be     latched write data and byte lanes, shared by all registers
//    reg_readdata/valid   packed per-register read data and read-valid from user logic
//    timeout_count        saturating read-timeout counter, present only with MM_REG_BANK_TIMEOUT_CNT_EN defined
module mm_reg_bank #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_SIZE    = 4,
   parameter int          ADDR_COUNT   = 2**ADDR_SIZE,
   parameter int          MAX_BURST    = 8,
   parameter int          BURST_W      = $clog2(MAX_BURST)+1,
   parameter int          TIMEOUT      = 1023,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
   input  logic                             mm_clk,
   input  logic                             rst,
   input  logic [ADDR_SIZE-1:0]             mm_address,
   input  logic [BURST_W-1:0]               mm_burstcount,
   output logic                             mm_waitrequest,
   input  logic                             mm_read,
   output logic [DATA_WIDTH-1:0]            mm_readdata,
   output logic                             mm_readdatavalid,
   input  logic                             mm_write,
   input  logic [DATA_WIDTH-1:0]            mm_writedata,
   input  logic [DATA_WIDTH/8-1:0]          mm_byteenable,
   output logic [ADDR_COUNT-1:0]            reg_write,
   output logic [ADDR_COUNT-1:0]            reg_read,
   output logic [DATA_WIDTH-1:0]            reg_writedata,
   output logic [DATA_WIDTH/8-1:0]          reg_byteenable,
   input  logic [ADDR_COUNT*DATA_WIDTH-1:0] reg_readdata,
   input  logic [ADDR_COUNT-1:0]            reg_readvalid,
   output logic [15:0]                      timeout_count
);

   localparam int TO_W = $clog2(TIMEOUT+1);
   localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(TIMEOUT_DATA);

   typedef enum logic [2:0] {IDLE, WR, RD_ACC, RD_REQ, RD_WAIT} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_SIZE-1:0]    addr_q;
   logic [BURST_W-1:0]      remain_q;
   logic [TO_W-1:0]         tcnt_q;

   logic                    in_range;
   logic [ADDR_COUNT-1:0]   addr_oh;
   logic                    sel_vld;
   logic [DATA_WIDTH-1:0]   sel_dat;
   logic                    cap;
   logic [DATA_WIDTH-1:0]   cap_dat;
   logic [BURST_W-1:0]      burst_len;
   logic [ADDR_SIZE-1:0]    addr_nxt;

   // Out-of-range addresses decode to no register at all, so strobes,
   // valid and data selection all collapse to zero for them.
   assign in_range = int'(addr_q) < ADDR_COUNT;
   assign addr_oh  = in_range ? (ADDR_COUNT'(1) << addr_q) : '0;
   assign sel_vld  = |(reg_readvalid & addr_oh);
   assign addr_nxt = (int'(addr_q) == ADDR_COUNT-1) ? '0 : addr_q + ADDR_SIZE'(1);

   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < ADDR_COUNT; i++)
         if (addr_oh[i]) sel_dat = sel_dat | reg_readdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // A burstcount of 0 means a single beat; oversize bursts are clamped.
   always_comb begin
      burst_len = mm_burstcount;
      if (mm_burstcount == '0)
         burst_len = BURST_W'(1);
      else if (mm_burstcount > BURST_W'(MAX_BURST))
         burst_len = BURST_W'(MAX_BURST);
   end

   // Capture decision: valid already high during the strobe cycle counts;
   // in the wait state, unmapped addresses complete at once with zero and a
   // missing valid is replaced by TO_DATA after TIMEOUT wait cycles.
   always_comb begin
      cap     = 1'b0;
      cap_dat = sel_dat;
      if (state == RD_REQ) begin
         cap = in_range && sel_vld;
      end else if (state == RD_WAIT) begin
         if (!in_range || sel_vld) begin
            cap = 1'b1;
         end else if (tcnt_q == TO_W'(TIMEOUT-1)) begin
            cap     = 1'b1;
            cap_dat = TO_DATA;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mm_write)     state_nxt = WR;
            else if (mm_read) state_nxt = RD_ACC;
         end
         WR:     state_nxt = IDLE;
         RD_ACC: state_nxt = RD_REQ;
         RD_REQ, RD_WAIT: begin
            if (cap)                state_nxt = (remain_q == BURST_W'(1)) ? IDLE : RD_REQ;
            else                    state_nxt = RD_WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mm_waitrequest = !((state == WR) || (state == RD_ACC));
   assign reg_write      = ((state == WR) && (reg_byteenable != '0)) ? addr_oh : '0;
   assign reg_read       = (state == RD_REQ) ? addr_oh : '0;

   always_ff @(posedge mm_clk) begin
      if (rst) begin
         state            <= IDLE;
         addr_q           <= '0;
         remain_q         <= '0;
         tcnt_q           <= '0;
         reg_writedata    <= '0;
         reg_byteenable   <= '0;
         mm_readdata      <= '0;
         mm_readdatavalid <= 1'b0;
      end else begin
         state            <= state_nxt;
         mm_readdatavalid <= cap;
         if (state == IDLE) begin
            if (mm_write) begin
               addr_q         <= mm_address;
               reg_writedata  <= mm_writedata;
               reg_byteenable <= mm_byteenable;
            end else if (mm_read) begin
               addr_q   <= mm_address;
               remain_q <= burst_len;
            end
         end
         if (state == RD_REQ)
            tcnt_q <= '0;
         else if (state == RD_WAIT && !cap)
            tcnt_q <= tcnt_q + TO_W'(1);
         if (cap) begin
            mm_readdata <= cap_dat;
            remain_q    <= remain_q - BURST_W'(1);
            addr_q      <= addr_nxt;
         end
      end
   end

`ifdef MM_REG_BANK_TIMEOUT_CNT_EN
   logic        to_hit;
   logic [15:0] tocnt_q;

   assign to_hit = (state == RD_WAIT) && in_range && !sel_vld && (tcnt_q == TO_W'(TIMEOUT-1));

   always_ff @(posedge mm_clk) begin
      if (rst)
         tocnt_q <= '0;
      else if (to_hit && (tocnt_q != 16'hFFFF))
         tocnt_q <= tocnt_q + 16'd1;
   end

   assign timeout_count = tocnt_q;
`else
   assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_mm_reg_bank.sv
module tb_mm_reg_bank;

   localparam int DW = 32;
   localparam int AS = 4;
   localparam int AC = 12;
   localparam int MB = 8;
   localparam int BW = 4;
   localparam int TO = 1023;

   logic            mm_clk = 1'b0;
   logic            rst    = 1'b1;
   logic [AS-1:0]   mm_address;
   logic [BW-1:0]   mm_burstcount;
   logic            mm_waitrequest;
   logic            mm_read;
   logic [DW-1:0]   mm_readdata;
   logic            mm_readdatavalid;
   logic            mm_write;
   logic [DW-1:0]   mm_writedata;
   logic [DW/8-1:0] mm_byteenable;
   logic [AC-1:0]   reg_write;
   logic [AC-1:0]   reg_read;
   logic [DW-1:0]   reg_writedata;
   logic [DW/8-1:0] reg_byteenable;
   logic [AC*DW-1:0] reg_readdata;
   logic [AC-1:0]   reg_readvalid;
   logic [15:0]     timeout_count;

   always #5 mm_clk = ~mm_clk;

   mm_reg_bank #(
      .DATA_WIDTH(DW), .ADDR_SIZE(AS), .ADDR_COUNT(AC), .MAX_BURST(MB),
      .BURST_W(BW), .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEADBEEF)
   ) dut (
      .mm_clk(mm_clk), .rst(rst), .mm_address(mm_address), .mm_burstcount(mm_burstcount),
      .mm_waitrequest(mm_waitrequest), .mm_read(mm_read), .mm_readdata(mm_readdata),
      .mm_readdatavalid(mm_readdatavalid), .mm_write(mm_write), .mm_writedata(mm_writedata),
      .mm_byteenable(mm_byteenable), .reg_write(reg_write), .reg_read(reg_read),
      .reg_writedata(reg_writedata), .reg_byteenable(reg_byteenable),
      .reg_readdata(reg_readdata), .reg_readvalid(reg_readvalid), .timeout_count(timeout_count)
   );

   int cyc = 0;
   always @(posedge mm_clk) cyc <= cyc + 1;

   // User-side registers: written through the strobes, answer reads either
   // immediately (tie_hi) or dly cycles after the read strobe; dly 0 = never.
   logic [31:0]   ureg [AC];
   logic          init_regs = 1'b1;
   logic [AC-1:0] tie_hi = '0;
   int            dly  [AC];
   int            dcnt [AC];

   always @(posedge mm_clk) begin
      for (int i = 0; i < AC; i++) begin
         if (init_regs)
            ureg[i] <= '0;
         else if (reg_write[i])
            for (int b = 0; b < 4; b++)
               if (reg_byteenable[b]) ureg[i][b*8 +: 8] <= reg_writedata[b*8 +: 8];
         if (reg_read[i])
            dcnt[i] <= tie_hi[i] ? 0 : dly[i];
         else if (dcnt[i] != 0)
            dcnt[i] <= dcnt[i] - 1;
      end
   end

   for (genvar g = 0; g < AC; g++) begin : g_user
      assign reg_readdata[g*DW +: DW] = ureg[g];
      assign reg_readvalid[g]         = tie_hi[g] | (dcnt[g] == 1);
   end

   // Event recorder, sampled 1 time unit after each rising edge.
   int            beat_cyc [$];
   logic [31:0]   beat_dat [$];
   int            strb_cyc [$];
   logic [AC-1:0] strb_oh  [$];
   int            wr_cyc   [$];
   logic [AC-1:0] wr_oh    [$];
   logic [31:0]   wr_dat   [$];
   logic [3:0]    wr_be    [$];

   always @(posedge mm_clk) begin
      #1;
      if (mm_readdatavalid) begin
         beat_cyc.push_back(cyc);
         beat_dat.push_back(mm_readdata);
      end
      if (reg_read != '0) begin
         strb_cyc.push_back(cyc);
         strb_oh.push_back(reg_read);
      end
      if (reg_write != '0) begin
         wr_cyc.push_back(cyc);
         wr_oh.push_back(reg_write);
         wr_dat.push_back(reg_writedata);
         wr_be.push_back(reg_byteenable);
      end
   end

   // Reference model state.
   logic [31:0] mregs [AC];
   int          exp_timeouts = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_total = 0;

   task automatic tick();
      @(posedge mm_clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      beat_cyc.delete(); beat_dat.delete(); strb_cyc.delete(); strb_oh.delete();
      wr_cyc.delete(); wr_oh.delete(); wr_dat.delete(); wr_be.delete();
   endtask

   // Present a command and hold it until the accept cycle; t = accept cycle.
   task automatic issue(input bit w, input bit r, input logic [3:0] a, input logic [3:0] bc,
                        input logic [31:0] d, input logic [3:0] be, output int t);
      mm_write = w; mm_read = r; mm_address = a; mm_burstcount = bc;
      mm_writedata = d; mm_byteenable = be;
      t = -1;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (!mm_waitrequest) begin
            t = cyc;
            break;
         end
      end
      check("accepted", (t >= 0), 1);
      tick();
      mm_write = 1'b0; mm_read = 1'b0;
      check("waitreq_after_accept", mm_waitrequest, 1);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                           input bit with_read);
      int  t;
      bit  hit;
      clear_mon();
      issue(1'b1, with_read, a, 4'd1, d, be, t);
      hit = (int'(a) < AC) && (be != 4'h0);
      if (hit)
         for (int b = 0; b < 4; b++)
            if (be[b]) mregs[a][b*8 +: 8] = d[b*8 +: 8];
      for (int k = 0; k < 4; k++) tick();
      check("wr_count", wr_cyc.size(), hit ? 1 : 0);
      if (hit && wr_cyc.size() > 0) begin
         check("wr_cycle", wr_cyc[0], t);
         check("wr_onehot", wr_oh[0], AC'(1) << a);
         check("wr_data", wr_dat[0], d);
         check("wr_be", wr_be[0], be);
      end
      check("wr_no_read_activity", beat_cyc.size() + strb_cyc.size(), 0);
   endtask

   task automatic do_read(input logic [3:0] a, input logic [3:0] bc);
      int            t, n, r, w, c, aa, last;
      logic [31:0]   dat;
      logic [AC-1:0] oh;
      int            eb_cyc [$];
      logic [31:0]   eb_dat [$];
      int            es_cyc [$];
      logic [AC-1:0] es_oh  [$];
      n = (bc == 0) ? 1 : ((int'(bc) > MB) ? MB : int'(bc));
      clear_mon();
      issue(1'b0, 1'b1, a, bc, $urandom, 4'hF, t);
      r  = t + 1;
      aa = int'(a);
      for (int j = 0; j < n; j++) begin
         if (aa < AC) begin
            oh = '0; oh[aa] = 1'b1;
            es_cyc.push_back(r); es_oh.push_back(oh);
         end
         if (aa >= AC) begin
            w = 1; dat = 32'h0;
         end else if (tie_hi[aa]) begin
            w = 0; dat = mregs[aa];
         end else if (dly[aa] >= 1 && dly[aa] <= TO) begin
            w = dly[aa]; dat = mregs[aa];
         end else begin
            w = TO; dat = 32'hDEADBEEF; exp_timeouts++;
         end
         c = r + w;
         eb_cyc.push_back(c + 1); eb_dat.push_back(dat);
         r  = c + 1;
         aa = (aa == AC-1) ? 0 : ((aa + 1) % 16);
      end
      last = eb_cyc[n-1];
      while (cyc < last + 3) tick();
      check("beat_count", beat_cyc.size(), n);
      check("strobe_count", strb_cyc.size(), es_cyc.size());
      for (int j = 0; j < n && j < beat_cyc.size(); j++) begin
         check("beat_cycle", beat_cyc[j] - t, eb_cyc[j] - t);
         check("beat_data", beat_dat[j], eb_dat[j]);
      end
      for (int j = 0; j < es_cyc.size() && j < strb_cyc.size(); j++) begin
         check("strobe_cycle", strb_cyc[j] - t, es_cyc[j] - t);
         check("strobe_onehot", strb_oh[j], es_oh[j]);
      end
   endtask

   task automatic check_tocnt();
`ifdef MM_REG_BANK_TIMEOUT_CNT_EN
      check("timeout_count", timeout_count, exp_timeouts);
`else
      check("timeout_count", timeout_count, 0);
`endif
   endtask

   initial begin
      int t;
      mm_write = 0; mm_read = 0; mm_address = 0; mm_burstcount = 0;
      mm_writedata = 0; mm_byteenable = 0;
      for (int i = 0; i < AC; i++) begin
         dly[i] = 1; mregs[i] = 32'h0;
      end

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_waitreq", mm_waitrequest, 1);
      check("rst_rdvalid", mm_readdatavalid, 0);
      check("rst_rddata", mm_readdata, 0);
      check("rst_reg_write", reg_write, 0);
      check("rst_reg_read", reg_read, 0);
      check("rst_wdata", reg_writedata, 0);
      check("rst_be", reg_byteenable, 0);
      check("rst_tocnt", timeout_count, 0);
      rst = 1'b0; init_regs = 1'b0;
      tick();

      tie_hi = '1;
      // Plain write with partial lanes
      do_write(4'd3, 32'h12345678, 4'b0101, 1'b0);
      // Dropped writes: no lanes, unmapped address
      do_write(4'd4, 32'hCAFEF00D, 4'b0000, 1'b0);
      do_write(4'd13, 32'h0BADF00D, 4'b1111, 1'b0);
      // Single read, valid tied high
      do_write(4'd2, 32'hA5A5A5A5, 4'hF, 1'b0);
      do_read(4'd2, 4'd1);
      do_read(4'd3, 4'd1);
      // Wrapping burst across ADDR_COUNT-1 -> 0
      do_write(4'd10, 32'h1010_1010, 4'hF, 1'b0);
      do_write(4'd11, 32'h1111_1111, 4'hF, 1'b0);
      do_write(4'd0,  32'h0000_AAAA, 4'hF, 1'b0);
      do_write(4'd1,  32'h0101_0101, 4'hF, 1'b0);
      do_read(4'd10, 4'd4);
      // Write wins over a simultaneous read
      do_write(4'd6, 32'h66666666, 4'b1100, 1'b1);
      // Unmapped read, burstcount 0 and oversize burst
      do_read(4'd13, 4'd2);
      do_read(4'd0, 4'd0);
      do_read(4'd0, 4'd15);
      // Delayed valid, ignoring valid on other registers
      tie_hi = '1; tie_hi[6] = 1'b0; dly[6] = 3;
      do_read(4'd6, 4'd1);
      // Timeout on a register that never answers
      tie_hi = '1; tie_hi[5] = 1'b0; dly[5] = 0;
      do_read(4'd5, 4'd1);
      check_tocnt();
      tie_hi = '1; dly[5] = 1; dly[6] = 1;

      // Reset during the second beat of a four-beat burst
      clear_mon();
      issue(1'b0, 1'b1, 4'd0, 4'd4, 32'h0, 4'hF, t);
      while (cyc < t + 3) tick();
      check("mid_rst_beats_before", beat_cyc.size(), 2);
      rst = 1'b1;
      exp_timeouts = 0;
      tick();
      check("mid_rst_waitreq", mm_waitrequest, 1);
      check("mid_rst_rdvalid", mm_readdatavalid, 0);
      check("mid_rst_rddata", mm_readdata, 0);
      rst = 1'b0;
      repeat (10) tick();
      check("mid_rst_beats_after", beat_cyc.size(), 2);
      check("mid_rst_strobes_after", strb_cyc.size(), 3);
      check_tocnt();
      do_read(4'd1, 4'd2);

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            tie_hi = AC'($urandom);
            for (int i = 0; i < AC; i++) dly[i] = $urandom_range(1, 4);
         end
         if ($urandom_range(0, 2) == 0)
            do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else
            do_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      check_tocnt();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
